// File: rtl/psum_ofifo.sv
// psum_ofifo: output FIFO for the partial sums leaving the south edge of a systolic array.
//
// There is one independent circular-buffer lane per array column. Columns can arrive
// skewed in time, so each column writes its own lane. A row read pops one entry from
// every lane at the same time, and it is accepted only when all lanes hold data.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high reset
//   in         : psum_bw*col packed input row, column j at [psum_bw*(j+1)-1 : psum_bw*j]
//   wr         : per-column write strobes
//   rd         : row-read request
//   out        : registered row read data, packed the same way as in
//   o_valid    : one-cycle pulse when out carries a newly popped row
//   o_ready    : every lane is non-empty
//   o_full     : at least one lane is full
//   o_overflow : sticky, set when a write to a full lane is dropped

module psum_ofifo #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int depth   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [psum_bw*col-1:0]   in,
    input  logic [col-1:0]           wr,
    input  logic                     rd,
    output logic [psum_bw*col-1:0]   out,
    output logic                     o_valid,
    output logic                     o_ready,
    output logic                     o_full,
    output logic                     o_overflow
);

    localparam int AW   = $clog2(depth);
    localparam int PtrW = AW + 1;

    logic [col-1:0]         lane_empty;
    logic [col-1:0]         lane_full;
    logic [col-1:0]         lane_drop;
    logic [psum_bw*col-1:0] rd_row;
    logic                   rd_accept;

    assign o_ready   = &(~lane_empty);
    assign o_full    = |lane_full;
    assign rd_accept = rd & o_ready;

    for (genvar j = 0; j < col; j++) begin : g_lane
        logic [AW:0]        wptr_q;
        logic [AW:0]        rptr_q;
        logic [psum_bw-1:0] mem [depth];
        logic               wr_ok;

        // The pointer MSB tells whether the write pointer has lapped the read pointer.
        assign lane_empty[j] = (wptr_q == rptr_q);
        assign lane_full[j]  = (wptr_q[AW] != rptr_q[AW]) &&
                               (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

        // A full lane still takes a write while a row is being popped in the same cycle.
        assign wr_ok        = wr[j] & (~lane_full[j] | rd_accept);
        assign lane_drop[j] = wr[j] & lane_full[j] & ~rd_accept;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                wptr_q <= '0;
                rptr_q <= '0;
            end else begin
                if (wr_ok) begin
                    wptr_q <= wptr_q + PtrW'(1);
                end
                if (rd_accept) begin
                    rptr_q <= rptr_q + PtrW'(1);
                end
            end
        end

        // Storage has no reset. Clearing the pointers makes any stale data unreachable.
        always_ff @(posedge clk) begin
            if (wr_ok) begin
                mem[wptr_q[AW-1:0]] <= in[psum_bw*j +: psum_bw];
            end
        end

        // This reads the old entry when a write to the same slot happens on the same edge.
        assign rd_row[psum_bw*j +: psum_bw] = mem[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out        <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_valid <= rd_accept;
            if (rd_accept) begin
                out <= rd_row;
            end
            if (|lane_drop) begin
                o_overflow <= 1'b1;
            end
        end
    end

endmodule
